// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: stall-bus layout,
// canned stall vectors, address width and the FSM state type.
package pipeline_ctrl_pkg;

  localparam int ADDR_BUS_WIDTH  = 32;
  localparam int STALL_BUS_WIDTH = 6;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // A requesting stage stalls itself and everything upstream; bit WB is never set.
  localparam logic [STALL_BUS_WIDTH-1:0] STALL_VEC_NONE = 6'b000000;
  localparam logic [STALL_BUS_WIDTH-1:0] STALL_VEC_IF   = 6'b000011;
  localparam logic [STALL_BUS_WIDTH-1:0] STALL_VEC_ID   = 6'b000111;
  localparam logic [STALL_BUS_WIDTH-1:0] STALL_VEC_EX   = 6'b001111;
  localparam logic [STALL_BUS_WIDTH-1:0] STALL_VEC_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } ctrl_state_e;

  function automatic logic [STALL_BUS_WIDTH-1:0] idle_stall_vec(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    if (req_mem)     return STALL_VEC_MEM;
    else if (req_ex) return STALL_VEC_EX;
    else if (req_id) return STALL_VEC_ID;
    else if (req_if) return STALL_VEC_IF;
    else             return STALL_VEC_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Counts consecutive cycles with the PC stalled and raises a sticky timeout flag
// once the count has reached WDOG_LIMIT.
module pipeline_ctrl_stall_watchdog #(
  parameter int WDOG_WIDTH = 8,
  parameter int WDOG_LIMIT = 200
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stall_pc_i,
  output logic timeout_o
);

  localparam logic [WDOG_WIDTH-1:0] LIMIT = WDOG_WIDTH'(WDOG_LIMIT);

  logic [WDOG_WIDTH-1:0] cnt_q, cnt_d;
  logic                  timeout_q;

  // Saturate rather than wrap so a very long stall never looks short.
  always_comb begin
    cnt_d = '0;
    if (stall_pc_i) cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_q == LIMIT) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges stall requests and runs
// exception entry (flush, then held PC redirect). Optional watchdog: STALL_WATCHDOG_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BUS_WIDTH,
  parameter int WDOG_WIDTH = 8,
  parameter int WDOG_LIMIT = 200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_req_if,
  input  logic                       stall_req_id,
  input  logic                       stall_req_ex,
  input  logic                       stall_req_mem,
  input  logic                       exc_valid,
  input  logic [ADDR_WIDTH-1:0]      exc_target,
  output logic [STALL_BUS_WIDTH-1:0] stall,
  output logic                       flush,
  output logic                       redirect_valid,
  output logic [ADDR_WIDTH-1:0]      redirect_addr,
  output logic                       wdog_timeout,
  output ctrl_state_e                state_o
);

  ctrl_state_e           state_q;
  logic                  flush_q;
  logic                  redirect_valid_q;
  logic [ADDR_WIDTH-1:0] redirect_addr_q;

  // Handshake: redirect_valid holds redirect_addr until the first edge with
  // stall_req_if low; the PC loads the address on that edge.
  always_comb begin
    stall = STALL_VEC_NONE;
    case (state_q)
      ST_IDLE:     stall = idle_stall_vec(stall_req_if, stall_req_id, stall_req_ex, stall_req_mem);
      ST_REDIRECT: stall = stall_req_if ? STALL_VEC_IF : STALL_VEC_NONE;
      default:     stall = STALL_VEC_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A MEM stall blocks the exception; it is simply re-sampled next cycle.
          if (exc_valid && !stall_req_mem) begin
            state_q         <= ST_FLUSH;
            flush_q         <= 1'b1;
            redirect_addr_q <= exc_target;
          end
        end
        ST_FLUSH: begin
          state_q          <= ST_REDIRECT;
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b1;
        end
        ST_REDIRECT: begin
          if (!stall_req_if) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= ST_IDLE;
          flush_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_addr  = redirect_addr_q;
  assign state_o        = state_q;

`ifdef STALL_WATCHDOG_EN
  pipeline_ctrl_stall_watchdog #(
    .WDOG_WIDTH (WDOG_WIDTH),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk_i      (clk),
    .rst_ni     (rst),
    .stall_pc_i (stall[STALL_PC]),
    .timeout_o  (wdog_timeout)
  );
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS32 pipeline.
- Merges per-stage stall requests into the 6-bit stall vector consumed by the PC register and every pipeline register.
- Each pipeline register gets (stall[n], stall[n+1]) as (stall_current_stage, stall_next_stage).
- Sequences exception entry: a one-cycle full-pipeline flush, then a held PC-redirect handshake.

Parameters:
ADDR_WIDTH, 32 (`ADDR_BUS_WIDTH), width of exception target / redirect address
WDOG_WIDTH, 8, width of stall watchdog counter (optional feature only)
WDOG_LIMIT, 200, consecutive PC-stall cycles before watchdog trips; must be < 2^WDOG_WIDTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
stall_req_if  in  1  fetch not ready
stall_req_id  in  1  load-use hazard
stall_req_ex  in  1  multi-cycle mult/div busy
stall_req_mem  in  1  data memory not ready
exc_valid  in  1  exception present at MEM
exc_target  in  ADDR_WIDTH  handler address
stall  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
flush  out  1  clear all pipeline registers
redirect_valid  out  1  PC must load redirect_addr
redirect_addr  out  ADDR_WIDTH  latched exc_target
wdog_timeout  out  1  sticky stall-watchdog flag

Behaviour:
- FSM states: IDLE, FLUSH, REDIRECT. The FSM state, flush, redirect_valid, redirect_addr and wdog_timeout are all registered.
- Reset (rst=0, async): state=IDLE, flush=0, redirect_valid=0, redirect_addr=0, wdog_timeout=0, watchdog count=0.
- Stall vector is combinational from the requests and the state. In IDLE the highest stage requesting wins:
  - mem: 011111
  - ex: 001111
  - id: 000111
  - if: 000011
  - none: 000000
  - Bit 5 is never driven.
- Resulting pipeline-register behaviour: the requesting stage holds, and a bubble is inserted into the next stage.
- IDLE→FLUSH on a clock edge where exc_valid=1 and stall_req_mem=0. exc_target is latched into redirect_addr on the same edge.
  - If exc_valid=1 and stall_req_mem=1, the exception is not taken. The MEM-stall vector applies and exc_valid is re-sampled each cycle.
- FLUSH (exactly 1 cycle):
  - flush=1 and stall=000000; all stall requests and exc_valid are ignored.
  - Next state is always REDIRECT.
- REDIRECT:
  - redirect_valid=1.
  - Stall vector is computed from stall_req_if only (000011 or 000000). id/ex/mem requests are ignored because the pipeline is empty.
  - Stay while stall_req_if=1. Go to IDLE on the first edge with stall_req_if=0; the PC accepts redirect_addr on that edge.
- exc_valid is ignored in FLUSH and REDIRECT.
- An exc_valid arriving in the same cycle as REDIRECT→IDLE is ignored; it is sampled only from IDLE onward.
- Async reset asserted mid-FLUSH/REDIRECT aborts the sequence immediately. No redirect is issued.

Optional Feature:
Macro STALL_WATCHDOG_EN.
- Defined:
  - WDOG_WIDTH counter increments each cycle stall[0]=1, cleared on any cycle stall[0]=0, saturating at all-ones.
  - When the count equals WDOG_LIMIT, wdog_timeout is set on the next edge and stays 1 until reset.
  - The watchdog has no effect on the stall vector or the FSM.
- Undefined: no counter is built and wdog_timeout is tied to 0.

Decomposition:
- Shared include (bus.v):
  - `STALL_BUS 5:0
  - `STALL_BUS_WIDTH 6
  - stall-bit index constants STALL_PC..STALL_WB
  - `ADDR_BUS_WIDTH
- Local to module: state encodings (2-bit localparams).
- One natural sub-module: stall_watchdog (counter + sticky flag), instantiated only under STALL_WATCHDOG_EN.

Test Plan:
1. Per-source stall: pulse each single request in IDLE → stall = 000011 / 000111 / 001111 / 011111 combinationally; mem+if together → 011111.
2. Exception: exc_valid=1, exc_target=0xBFC00380, no stalls → next cycle flush=1 and stall=0; following cycle redirect_valid=1, redirect_addr=0xBFC00380; then IDLE with both low.
3. Exception blocked by MEM stall: exc_valid=1 with stall_req_mem=1 for 3 cycles → stall=011111, flush stays 0; mem releases → flush on the next cycle.
4. Redirect backpressure: stall_req_if=1 during REDIRECT for 4 cycles → redirect_valid held 4 cycles with stall=000011; stall_req_ex ignored there.
5. Reset mid-sequence: drop rst during FLUSH → flush, redirect_valid and redirect_addr go 0 immediately; after release, FSM is IDLE and no redirect occurs.
6. Watchdog (STALL_WATCHDOG_EN, WDOG_LIMIT=10):
   - stall_req_ex held 10 cycles → wdog_timeout=1 on the following edge and stays 1 after the request drops.
   - Holding only 9 cycles → stays 0.
